mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Round-robin scheduler sharing one pipelined 32x32 multiplier between NREQ requesters in the MAC datapath. Each requester presents operands with per-operand unsigned flags over a valid/ready handshake. The block issues at most one operation per cycle into an internal registered multiplier pipeline and returns a 64-bit product tagged with the requester index. The response port supports backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 32, operand width
- LAT, 2, issue-to-response latency in cycles (>=2)
- IDW, $clog2(NREQ), response tag width
- i_clk  in  1  clock
- i_rstn  in  1  reset: asynchronous, active-low
- i_req_valid  in  NREQ  per-requester request valid
- o_req_ready  out  NREQ  per-requester accept; at most one bit set
- i_req_multa  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- i_req_multb  in  NREQ*W  operand B, same packing
- i_req_multa_ns  in  NREQ  1 = operand A unsigned, 0 = signed
- i_req_multb_ns  in  NREQ  1 = operand B unsigned, 0 = signed
- o_rsp_valid  out  1  product valid
- i_rsp_ready  in  1  consumer accepts product
- o_rsp_id  out  IDW  index of the originating requester
- o_rsp_product  out  2W  product
- o_busy  out  1  any pipeline stage holds a valid operation

## Operation
- Arbitration: round-robin. Search starts at pointer `rr_ptr` and selects the first i with i_req_valid[i]. Ties cannot occur.
- `rr_ptr` resets to 0. After an accepted grant to index g, it becomes (g+1) mod NREQ. It holds when nothing is accepted.
- `adv = ~o_rsp_valid | i_rsp_ready`. The whole pipeline shifts only when adv=1, including bubbles.
- `o_req_ready[g] = adv & grant[g]`. This is combinational from i_req_valid. Requesters must not make valid depend on ready.
- A transfer occurs when valid[i] and ready[i] are both high at a clock edge. That operation's valid, id, operands and flags enter stage 1.
- Operand extension: each operand is extended to W+1 bits, with a zero extension if its ns flag is 1 and a sign extension if it is 0. The (W+1)x(W+1) signed product is truncated to the low 2W bits, which is exact for all flag mixes.
- Stage 1 registers the operands. The multiply sits between stage 1 and stage 2. Stages 2..LAT register the product, id and valid.
- o_rsp_* are driven directly from stage LAT.
- Stall (o_rsp_valid=1 and i_rsp_ready=0):
  - All stages hold.
  - o_req_ready is all 0.
  - o_rsp_id and o_rsp_product are stable until accepted.
- Reset, asynchronous at any time:
  - All stage valids, `rr_ptr`, ids, operands and products are set to 0.
  - In-flight operations are discarded and no response is produced for them.
- Output values during reset: o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_product=0, o_busy=0.
- o_busy is the OR of all stage valid bits.

## Timing
- The first edge after i_rstn deasserts behaves as normal operation. No warm-up cycles.
- Operation accepted at edge T with no stall: o_rsp_valid is high after edge T+LAT-1, i.e. LAT edges from request to response register.
- Throughput is 1 op/cycle while i_rsp_ready=1.
- Each stall cycle adds exactly 1 cycle to the latency of every in-flight operation.
- Responses leave in acceptance order. There is no reordering.
- Simultaneous events:
  - When the response is accepted and a new request is accepted in the same edge, both take effect: the pipeline shifts and the new op enters stage 1.
  - When a requester drops valid in a cycle with no ready, nothing is issued and `rr_ptr` holds.
- Requester ordering guarantee: with all NREQ requesters continuously valid, each is granted exactly once per NREQ accepted operations.

## Structure
- Package `mult_share_pkg` holds:
  - default W, LAT, NREQ constants;
  - the product width localparam PW=2*W;
  - a stage-record typedef (valid, id, product or operands).
- Sub-module `mult_pipe` is the pipelined signed/unsigned multiplier. It takes operands and flags in, exposes an enable (adv), and outputs the product after LAT registers. It carries id/valid alongside.
- Round-robin arbitration and the handshake logic stay in the top module, with no separate arbiter module.

## Test plan
- Requester 0 only, A=3, B=5, both ns=1, rsp_ready=1 -> o_rsp_valid LAT cycles after acceptance, id=0, product=0x000000000000000F.
- Requester 1, A=0xFFFFFFFF, B=2, both ns=0 -> product 0xFFFFFFFFFFFFFFFE. Same operands with both ns=1 -> 0x00000001FFFFFFFE. With A ns=0, B ns=1 and B=0xFFFFFFFF, A=0xFFFFFFFF -> 0xFFFFFFFF00000001.
- All 4 requesters continuously valid with distinct operands -> grants 0,1,2,3,0,1 on consecutive cycles; responses ids 0,1,2,3,0,1 back-to-back with correct products.
- 4 ops in flight, i_rsp_ready held low 3 cycles -> o_rsp_valid held with a stable id/product; o_req_ready all 0; on release all 4 products are delivered in order with none lost or duplicated.
- Requester 2 accepted alone; next cycle requesters 1 and 3 both valid -> requester 3 granted first, then 1.
- 2 ops in flight, i_rstn pulsed low mid-cycle -> all outputs 0 immediately; after release there is no stale response, o_busy=0, and the next grant search starts at index 0.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared constants and types for the shared-multiplier scheduler.
package mult_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 32;
    localparam int LAT_DEF  = 2;
    localparam int PW       = 2 * W_DEF;
    localparam int IDW_MAX  = 3;

    // One product-pipeline stage in the default configuration.
    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
        logic [PW-1:0]      product;
    } stage_t;

endpackage

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier: stage 1 holds extended operands,
// stages 2..LAT hold the product.
// The tag (id) and the valid bit travel alongside the operation.
// The whole pipeline shifts only while i_en is high.
module mult_pipe
    import mult_share_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int LAT = LAT_DEF,
    parameter int IDW = 2
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_en,
    input  logic           i_valid,
    input  logic [IDW-1:0] i_id,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_a_ns,
    input  logic           i_b_ns,
    output logic           o_valid,
    output logic [IDW-1:0] o_id,
    output logic [2*W-1:0] o_product,
    output logic           o_busy
);

    localparam int NP = LAT - 1;

    logic           r_s1_valid;
    logic [IDW-1:0] r_s1_id;
    logic [W:0]     r_s1_a;
    logic [W:0]     r_s1_b;

    logic [W:0]     w_a_ext;
    logic [W:0]     w_b_ext;
    logic [2*W-1:0] w_a_wide;
    logic [2*W-1:0] w_b_wide;
    logic [2*W-1:0] w_prod;

    logic [NP-1:0]  r_pv;
    logic [IDW-1:0] r_pid [NP];
    logic [2*W-1:0] r_pp  [NP];

    // The ns flag selects zero extension, otherwise sign extension, to W+1 bits.
    assign w_a_ext = i_a_ns ? {1'b0, i_a} : {i_a[W-1], i_a};
    assign w_b_ext = i_b_ns ? {1'b0, i_b} : {i_b[W-1], i_b};

    // Sign-extend to 2W.
    // The low 2W bits of the modular product then equal the exact
    // (W+1)x(W+1) signed product, truncated to 2W bits.
    assign w_a_wide = {{(W-1){r_s1_a[W]}}, r_s1_a};
    assign w_b_wide = {{(W-1){r_s1_b[W]}}, r_s1_b};
    assign w_prod   = w_a_wide * w_b_wide;

    // Stage 1: capture the extended operands of the op (or bubble) entering now.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (i_en) begin
            r_s1_valid <= i_valid;
            r_s1_id    <= i_id;
            r_s1_a     <= w_a_ext;
            r_s1_b     <= w_b_ext;
        end
    end

    // Stages 2..LAT: register the product and carry the tag and valid bit forward.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pv <= '0;
            for (int k = 0; k < NP; k++) begin
                r_pid[k] <= '0;
                r_pp[k]  <= '0;
            end
        end else if (i_en) begin
            r_pv[0]  <= r_s1_valid;
            r_pid[0] <= r_s1_id;
            r_pp[0]  <= w_prod;
            for (int k = 1; k < NP; k++) begin
                r_pv[k]  <= r_pv[k-1];
                r_pid[k] <= r_pid[k-1];
                r_pp[k]  <= r_pp[k-1];
            end
        end
    end

    assign o_valid   = r_pv[NP-1];
    assign o_id      = r_pid[NP-1];
    assign o_product = r_pp[NP-1];
    assign o_busy    = r_s1_valid | (|r_pv);

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one pipelined multiplier between NREQ requesters.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. o_req_ready is combinational from i_req_valid, so requesters must
// not make valid depend on ready. A response is consumed on an edge with
// o_rsp_valid and i_rsp_ready both high. While a response waits (stall),
// the pipeline holds and o_req_ready stays 0.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int LAT  = LAT_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [NREQ*W-1:0] i_req_multa,
    input  logic [NREQ*W-1:0] i_req_multb,
    input  logic [NREQ-1:0]   i_req_multa_ns,
    input  logic [NREQ-1:0]   i_req_multb_ns,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [2*W-1:0]    o_rsp_product,
    output logic              o_busy
);

    logic [IDW-1:0]  r_rr_ptr;
    logic            w_adv;
    logic            w_gany;
    logic [IDW-1:0]  w_gidx;
    logic [NREQ-1:0] w_grant;
    logic            w_accept;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_a_ns;
    logic            w_b_ns;

    // Index that lies off positions after base, modulo NREQ.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NREQ;
        return IDW'(s);
    endfunction

    assign w_adv = ~o_rsp_valid | i_rsp_ready;

    // Round-robin search from r_rr_ptr.
    // The loop runs backwards, so the nearest valid requester is assigned last and wins.
    always_comb begin
        w_gany = 1'b0;
        w_gidx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_gany = 1'b1;
                w_gidx = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    // Decode the winner to a one-hot vector.
    always_comb begin
        w_grant = '0;
        if (w_gany) w_grant[w_gidx] = 1'b1;
    end

    // Ready goes to the winner only while the pipeline can advance and reset is released.
    assign o_req_ready = (w_adv && i_rstn) ? w_grant : '0;
    assign w_accept    = w_adv & w_gany;

    assign w_a    = i_req_multa[w_gidx*W +: W];
    assign w_b    = i_req_multb[w_gidx*W +: W];
    assign w_a_ns = i_req_multa_ns[w_gidx];
    assign w_b_ns = i_req_multb_ns[w_gidx];

    // Move the round-robin pointer past the requester that was just accepted.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    mult_pipe #(
        .W   (W),
        .LAT (LAT),
        .IDW (IDW)
    ) u_pipe (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_en      (w_adv),
        .i_valid   (w_accept),
        .i_id      (w_gidx),
        .i_a       (w_a),
        .i_b       (w_b),
        .i_a_ns    (w_a_ns),
        .i_b_ns    (w_b_ns),
        .o_valid   (o_rsp_valid),
        .o_id      (o_rsp_id),
        .o_product (o_rsp_product),
        .o_busy    (o_busy)
    );

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl.
// Stimulus is driven 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;
  localparam int IDW  = 2;
  localparam int PW   = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_a_ns;
  logic [NREQ-1:0]   req_b_ns;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [PW-1:0]     rsp_product;
  logic              busy;

  mult_share_ctrl #(.NREQ(NREQ), .W(W), .LAT(LAT), .IDW(IDW)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_multa    (req_a),
    .i_req_multb    (req_b),
    .i_req_multa_ns (req_a_ns),
    .i_req_multb_ns (req_b_ns),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (rsp_id),
    .o_rsp_product  (rsp_product),
    .o_busy         (busy)
  );

  // ---------------- scoreboard ----------------
  // Each in-flight op has a count of pipeline advances still needed before it
  // reaches the response port.
  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  prod;
    int             cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;

  // Reference product: extend each operand to 64 bits as a signed or unsigned
  // integer, then multiply modulo 2^64.
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ans, input logic bns);
    logic [PW-1:0] a64;
    logic [PW-1:0] b64;
    a64 = ans ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    b64 = bns ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    return a64 * b64;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor.
  // Runs on each falling edge and predicts what the next rising edge does.
  always @(negedge clk) begin
    if (rstn) begin
      logic            mv;
      logic            adv_m;
      logic [NREQ-1:0] eg;
      int              g;
      exp_t            e;
      mv = (exp_q.size() > 0) && (exp_q[0].cnt == 0);
      check("busy", PW'(busy), PW'(exp_q.size() != 0));
      check("rsp_valid", PW'(rsp_valid), PW'(mv));
      if (mv && rsp_valid) begin
        check("rsp_id", PW'(rsp_id), PW'(exp_q[0].id));
        check("rsp_product", rsp_product, exp_q[0].prod);
      end
      adv_m = !mv || rsp_ready;
      g = -1;
      if (adv_m) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      check("req_ready", PW'(req_ready), PW'(eg));
      if (mv && rsp_ready) void'(exp_q.pop_front());
      if (adv_m) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          e = exp_q[i];
          if (e.cnt > 0) e.cnt--;
          exp_q[i] = e;
        end
      end
      if (g >= 0) begin
        e.id   = IDW'(g);
        e.prod = ref_mul(req_a[g*W +: W], req_b[g*W +: W], req_a_ns[g], req_b_ns[g]);
        e.cnt  = LAT - 1;
        exp_q.push_back(e);
        m_ptr = (g + 1) % NREQ;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ans, input logic bns);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_a_ns[i] = ans;
    req_b_ns[i] = bns;
  endtask

  task automatic one_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ans, input logic bns);
    set_req(i, a, b, ans, bns);
    req_valid = '0;
    req_valid[i] = 1'b1;
    tick(1);
    req_valid = '0;
    tick(LAT + 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", PW'(req_ready), '0);
    check("rst_rsp_valid", PW'(rsp_valid), '0);
    check("rst_rsp_id", PW'(rsp_id), '0);
    check("rst_rsp_product", rsp_product, '0);
    check("rst_busy", PW'(busy), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_a_ns = '0;
    req_b_ns = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    req_valid = '0;
    @(posedge clk);
    #3 rstn = 1'b1;
    tick(1);

    // Single requester, directed operand and flag mixes.
    one_op(0, 32'd3, 32'd5, 1'b1, 1'b1);
    one_op(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    one_op(1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1);
    one_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    one_op(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // All requesters continuously valid, with distinct operands.
    for (int i = 0; i < NREQ; i++)
      set_req(i, 32'(100 + i), 32'(7 * i + 1), i[0], i[1]);
    req_valid = '1;
    tick(8);
    req_valid = '0;
    tick(LAT + 2);

    // Backpressure while ops are in flight.
    req_valid = '1;
    tick(4);
    rsp_ready = 1'b0;
    tick(3);
    rsp_ready = 1'b1;
    tick(2);
    req_valid = '0;
    tick(LAT + 3);

    // Requester 2 alone, then 1 and 3 together: 3 must be granted before 1.
    req_valid = 4'b0100;
    tick(1);
    req_valid = 4'b1010;
    tick(2);
    req_valid = '0;
    tick(LAT + 2);

    // Asynchronous reset while two ops are in flight.
    req_valid = '1;
    tick(2);
    @(posedge clk);
    #3 rstn = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    #1;
    check_reset_outputs();
    tick(2);
    check_reset_outputs();
    @(posedge clk);
    #3 rstn = 1'b1;
    req_valid = '0;
    tick(1);
    req_valid = 4'b1111;
    tick(3);
    req_valid = '0;
    tick(LAT + 2);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
        set_req(i, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    // Drain within a bounded number of cycles.
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick(1);
    check("drain_queue_empty", PW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
